// File: rtl/bus_scan_pkg.sv
// Shared definitions for the bus scan transmitter.
// Contents:
//   state_t    - scan/frame state encoding used by the top-level FSM
//   DEF_NREG   - default number of bus source slots
//   DEF_DW     - default bus/data width
//   FRAME_BITS - serial bits per slot: one start bit, DW data bits, one stop bit
//   LINE_IDLE  - level of the serial line when no frame is being sent
//   LINE_START - level of the start bit
//   frame_bits - frame length for an arbitrary data width
package bus_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_WAIT,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   localparam int DEF_NREG = 4;
   localparam int DEF_DW = 4;
   localparam int FRAME_BITS = DEF_DW + 2;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic LINE_START = 1'b0;

   function automatic int frame_bits(input int dw);
      return dw + 2;
   endfunction

endpackage

// File: rtl/bus_scan_tx_serializer.sv
// Parallel-to-serial helper for the bus scan transmitter.
// Holds the captured bus value, shifts it right one place per shift request
// and counts how many bits have already been moved onto the line.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   load     in   capture data and clear the bit counter
//   data     in   [DW-1:0] value to capture
//   shift    in   advance to the next bit (shift right, count up)
//   cur_bit  out  bit currently at the LSB of the shift register
//   next_bit out  bit that becomes the LSB after the next shift
//   last     out  the LSB is the final data bit of the frame
module bit_serializer
   import bus_scan_pkg::*;
#(
   parameter int DW = DEF_DW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] data,
   input  logic          shift,
   output logic          cur_bit,
   output logic          next_bit,
   output logic          last
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   logic [DW-1:0] shreg;
   logic [DW-1:0] shifted;
   logic [CW-1:0] count;

   // The register is loaded once per slot and then only shifted, so the
   // captured value stays frozen no matter what the bus does afterwards.
   // The counter tracks which data bit is on the line; the last bit is never
   // shifted past, so the counter tops out at DW-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         count <= '0;
      end else if (load) begin
         shreg <= data;
         count <= '0;
      end else if (shift) begin
         shreg <= shifted;
         count <= count + 1'b1;
      end
   end

   // The top registers tx from next_bit on the same edge that shifts, so the
   // line and the register stay in step.
   assign shifted  = shreg >> 1;
   assign cur_bit  = shreg[0];
   assign next_bit = shifted[0];
   assign last     = (count == CW'(DW - 1));

endmodule

// File: rtl/bus_scan_tx.sv
// Bus scan transmitter: on a start pulse, steps the bus-mux select through
// every source slot, captures each bus value and sends it out as a
// start / LSB-first data / stop frame, one bit per tick.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   start   in   one-cycle scan request (honoured only when idle)
//   tick    in   one-cycle bit-rate enable
//   bus_in  in   [DW-1:0] shared register bus from the bus mux
//   sel     out  [SW-1:0] bus-mux select, 0..NREG-1
//   tx      out  serial line, idle high
//   busy    out  high for the whole scan
//   done    out  one-cycle pulse when the final stop bit ends
module bus_scan_tx
   import bus_scan_pkg::*;
#(
   parameter int NREG = DEF_NREG,
   parameter int DW = DEF_DW,
   localparam int SW = (NREG > 1) ? $clog2(NREG) : 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          tick,
   input  logic [DW-1:0] bus_in,
   output logic [SW-1:0] sel,
   output logic          tx,
   output logic          busy,
   output logic          done
);

   state_t state;

   logic ser_load;
   logic ser_shift;
   logic ser_cur;
   logic ser_next;
   logic ser_last;

   // Capture happens in its own state, two clocks after the select settles,
   // so the mux output has a full cycle to propagate. A data tick shifts
   // only while more data bits remain; the final tick moves to the stop bit.
   assign ser_load  = (state == ST_CAPTURE);
   assign ser_shift = (state == ST_DATA) && tick && !ser_last;

   bit_serializer #(
      .DW(DW)
   ) u_serializer (
      .clk     (clk),
      .rst     (rst),
      .load    (ser_load),
      .data    (bus_in),
      .shift   (ser_shift),
      .cur_bit (ser_cur),
      .next_bit(ser_next),
      .last    (ser_last)
   );

   // Scan sequencer. Every output is a register updated on the same edge
   // that samples tick, so each bit lasts exactly one tick interval. Ticks
   // seen in IDLE, SETTLE or CAPTURE are deliberately ignored; a frame always
   // begins on the first tick seen in WAIT. done is a single-cycle pulse, and
   // since the final stop edge leaves the FSM in IDLE, a start arriving on
   // that same edge is seen by STOP and dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         sel   <= '0;
         tx    <= LINE_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               tx  <= LINE_IDLE;
               sel <= '0;
               if (start) begin
                  state <= ST_SETTLE;
                  busy  <= 1'b1;
               end
            end
            ST_SETTLE: begin
               state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (tick) begin
                  state <= ST_START;
                  tx    <= LINE_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  state <= ST_DATA;
                  tx    <= ser_cur;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (ser_last) begin
                     state <= ST_STOP;
                     tx    <= LINE_IDLE;
                  end else begin
                     tx <= ser_next;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (sel == SW'(NREG - 1)) begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     sel   <= '0;
                  end else begin
                     state <= ST_SETTLE;
                     sel   <= sel + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               sel   <= '0;
               tx    <= LINE_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_scan_tx.sv
// Self-checking bench for bus_scan_tx: a procedural reference model tracks
// what tx/busy/sel/done must be on every cycle, and a simple line receiver
// decodes frames so they can be compared to hand-computed bit patterns.
module tb_bus_scan_tx;

   localparam int NREG = 4;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          tick = 1'b0;
   logic [DW-1:0] bus_in;
   logic [1:0]    sel;
   logic          tx;
   logic          busy;
   logic          done;

   logic          start2;
   logic [DW-1:0] bus_in2;
   logic [0:0]    sel2;
   logic          tx2;
   logic          busy2;
   logic          done2;

   logic [DW-1:0] slot_val [NREG];
   logic          ov_en;
   logic [DW-1:0] ov_val;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int tick_period = 4;
   bit tick_en = 1'b0;
   bit check_en = 1'b0;

   // The bench plays the bus mux, with an override to disturb the bus.
   assign bus_in  = ov_en ? ov_val : slot_val[sel];
   assign bus_in2 = slot_val[{1'b0, sel2}];

   bus_scan_tx #(.NREG(NREG), .DW(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .tick  (tick),
      .bus_in(bus_in),
      .sel   (sel),
      .tx    (tx),
      .busy  (busy),
      .done  (done)
   );

   bus_scan_tx #(.NREG(2), .DW(DW)) dut2 (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .tick  (tick),
      .bus_in(bus_in2),
      .sel   (sel2),
      .tx    (tx2),
      .busy  (busy2),
      .done  (done2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) tick = tick_en && ((cyc % tick_period) == 0);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   // Reference model: the scan written as a sequence of waits on edges.
   logic exp_tx = 1'b1;
   logic exp_busy = 1'b0;
   logic exp_done = 1'b0;
   int   exp_sel = 0;

   task automatic step(output bit ab);
      @(posedge clk);
      exp_done = 1'b0;
      ab = rst;
      if (rst) begin
         exp_tx = 1'b1;
         exp_busy = 1'b0;
         exp_sel = 0;
      end
   endtask

   task automatic wait_tick(output bit ab);
      do step(ab); while (!ab && !tick);
   endtask

   task automatic run_scan();
      bit ab;
      logic [DW-1:0] val;
      exp_busy = 1'b1;
      exp_sel = 0;
      for (int s = 0; s < NREG; s++) begin
         exp_sel = s;
         step(ab); if (ab) return;
         step(ab); if (ab) return;
         val = ov_en ? ov_val : slot_val[s];
         wait_tick(ab); if (ab) return;
         exp_tx = 1'b0;
         for (int b = 0; b < DW; b++) begin
            wait_tick(ab); if (ab) return;
            exp_tx = val[b];
         end
         wait_tick(ab); if (ab) return;
         exp_tx = 1'b1;
         wait_tick(ab); if (ab) return;
         if (s == NREG - 1) begin
            exp_done = 1'b1;
            exp_busy = 1'b0;
            exp_sel = 0;
         end else begin
            exp_sel = s + 1;
         end
      end
   endtask

   initial begin : model
      bit ab;
      forever begin
         step(ab);
         if (!ab && start === 1'b1) run_scan();
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("model_tx", tx, exp_tx);
         checkOutput("model_busy", busy, exp_busy);
         checkOutput("model_sel", sel, exp_sel);
         checkOutput("model_done", done, exp_done);
      end
   end

   // Line receiver: finds a falling edge, then samples mid-bit.
   logic [5:0] rx_q[$];
   int         rx_t[$];
   int         rx_period = 4;

   initial begin : receiver
      logic prev;
      logic [5:0] f;
      int p;
      int t0;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && tx === 1'b0) begin
            p = rx_period;
            t0 = cyc;
            repeat (p / 2) @(negedge clk);
            f[0] = tx;
            for (int k = 1; k < 6; k++) begin
               repeat (p) @(negedge clk);
               f[k] = tx;
            end
            rx_q.push_back(f);
            rx_t.push_back(t0);
         end
         prev = tx;
      end
   end

   // Logs of select changes, done pulses and line toggles.
   int   sel_q[$];
   int   sel2_q[$];
   int   last_sel = 0;
   int   last_sel2 = 0;
   int   done_cnt = 0;
   int   done2_cnt = 0;
   int   tog = 0;
   bit   tog_en = 1'b0;
   logic tx_prev = 1'b1;

   always @(negedge clk) begin
      if (int'(sel) != last_sel) begin
         sel_q.push_back(int'(sel));
         last_sel = int'(sel);
      end
      if (int'(sel2) != last_sel2) begin
         sel2_q.push_back(int'(sel2));
         last_sel2 = int'(sel2);
      end
      if (done === 1'b1) done_cnt++;
      if (done2 === 1'b1) done2_cnt++;
      if (tog_en && tx !== tx_prev) tog++;
      tx_prev = tx;
   end

   task automatic clearLogs();
      rx_q.delete();
      rx_t.delete();
      sel_q.delete();
      sel2_q.delete();
      sel_q.push_back(0);
      sel2_q.push_back(0);
      last_sel = 0;
      last_sel2 = 0;
      done_cnt = 0;
      done2_cnt = 0;
   endtask

   // One-cycle start pulse placed on a tick cycle, so the coincident tick
   // must be ignored.
   task automatic applyStimulus(input bit second);
      do @(negedge clk); while ((cyc % tick_period) != 0);
      if (second) start2 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic waitDone(input bit second, input int budget, input string name);
      int n;
      n = 0;
      while (((second ? done2 : done) !== 1'b1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, second ? done2 : done, 1);
   endtask

   task automatic checkFrames(input string name, input logic [5:0] f0, input logic [5:0] f1,
                              input logic [5:0] f2, input logic [5:0] f3);
      logic [5:0] want [4];
      want = '{f0, f1, f2, f3};
      checkOutput({name, "_count"}, rx_q.size(), 4);
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("%s_frame%0d", name, i), (i < rx_q.size()) ? rx_q[i] : 6'bxxxxxx, want[i]);
   endtask

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int exp_seq [5];
      rst = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      ov_en = 1'b0;
      ov_val = '0;
      slot_val = '{4'h5, 4'hA, 4'h3, 4'h0};
      repeat (2) @(negedge clk);
      checkOutput("reset_tx", tx, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_sel", sel, 0);
      checkOutput("reset_done", done, 0);
      check_en = 1'b1;
      rst = 1'b0;
      tick_en = 1'b1;
      tick_period = 4;
      rx_period = 4;
      repeat (6) @(negedge clk);

      $display("[TB] single scan, tick every 4 clocks");
      clearLogs();
      applyStimulus(1'b0);
      waitDone(1'b0, 400, "scan1_done");
      repeat (30) @(negedge clk);
      checkFrames("scan1", 6'b101010, 6'b110100, 6'b100110, 6'b100000);
      exp_seq = '{0, 1, 2, 3, 0};
      checkOutput("scan1_sel_steps", sel_q.size(), 5);
      for (int i = 0; i < 5; i++)
         checkOutput($sformatf("scan1_sel%0d", i), (i < sel_q.size()) ? sel_q[i] : -1, exp_seq[i]);
      checkOutput("scan1_done_count", done_cnt, 1);

      $display("[TB] bus disturbed after capture");
      clearLogs();
      applyStimulus(1'b0);
      @(negedge clk);
      @(negedge clk);
      ov_val = 4'hF;
      ov_en = 1'b1;
      repeat (10) @(negedge clk);
      ov_en = 1'b0;
      waitDone(1'b0, 400, "frozen_done");
      repeat (30) @(negedge clk);
      checkFrames("frozen", 6'b101010, 6'b110100, 6'b100110, 6'b100000);

      $display("[TB] start held high through the scan");
      clearLogs();
      do @(negedge clk); while ((cyc % tick_period) != 0);
      start = 1'b1;
      for (int n = 0; n < 400 && done !== 1'b1; n++) @(negedge clk);
      start = 1'b0;
      checkOutput("held_done_seen", done, 1);
      repeat (40) @(negedge clk);
      checkOutput("held_done_count", done_cnt, 1);
      checkOutput("held_frames", rx_q.size(), 4);
      checkOutput("held_busy_end", busy, 0);

      $display("[TB] tick tied high, all slots 0xF");
      slot_val = '{4'hF, 4'hF, 4'hF, 4'hF};
      tick_period = 1;
      rx_period = 1;
      repeat (4) @(negedge clk);
      clearLogs();
      applyStimulus(1'b0);
      waitDone(1'b0, 200, "fast_done");
      repeat (20) @(negedge clk);
      checkFrames("fast", 6'b111110, 6'b111110, 6'b111110, 6'b111110);
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("fast_gap%0d", i), (i + 1 < rx_t.size()) ? rx_t[i + 1] - rx_t[i] : -1, 9);

      $display("[TB] reset in the middle of a frame");
      slot_val = '{4'h5, 4'hA, 4'h3, 4'h0};
      tick_period = 4;
      rx_period = 4;
      repeat (4) @(negedge clk);
      applyStimulus(1'b0);
      repeat (14) @(negedge clk);
      checkOutput("midframe_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_tx", tx, 1);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_sel", sel, 0);
      checkOutput("abort_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      clearLogs();
      tog = 0;
      tog_en = 1'b1;
      repeat (40) @(negedge clk);
      tog_en = 1'b0;
      checkOutput("abort_no_toggle", tog, 0);
      checkOutput("abort_no_done", done_cnt, 0);

      $display("[TB] two-slot instance");
      clearLogs();
      applyStimulus(1'b1);
      waitDone(1'b1, 300, "nreg2_done");
      repeat (10) @(negedge clk);
      checkOutput("nreg2_sel_steps", sel2_q.size(), 3);
      exp_seq = '{0, 1, 0, 0, 0};
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("nreg2_sel%0d", i), (i < sel2_q.size()) ? sel2_q[i] : -1, exp_seq[i]);
      checkOutput("nreg2_done_count", done2_cnt, 1);
      checkOutput("nreg2_busy_end", busy2, 0);
      checkOutput("nreg2_tx_idle", tx2, 1);
      checkOutput("nreg2_main_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
